// File: rtl/gpu_pkg.sv
// Shared GPU parameters and the fetch tag that travels alongside each IMEM read.
package gpu_pkg;

  localparam int NUM_SIMD_CORES  = 4;
  localparam int LOG2_SIMD_CORES = $clog2(NUM_SIMD_CORES);

  typedef struct packed {
    logic                       valid;
    logic [LOG2_SIMD_CORES-1:0] core_id;
  } fetch_tag_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick: first eligible requester at or above rr_ptr_i, wrapping.
// Purely combinational (zero latency); any_grant_o low when nothing is eligible.
module rr_arbiter #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] eligible_i,
  input  logic [W-1:0] rr_ptr_i,
  output logic [N-1:0] grant_o,
  output logic [W-1:0] winner_o,
  output logic         any_grant_o
);

  logic [W-1:0] idx;

  // Walk from farthest to nearest so the requester closest to the pointer wins.
  always_comb begin
    grant_o     = '0;
    winner_o    = '0;
    any_grant_o = 1'b0;
    idx         = '0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = W'((int'(rr_ptr_i) + k) % N);
      if (eligible_i[idx]) begin
        grant_o      = '0;
        grant_o[idx] = 1'b1;
        winner_o     = idx;
        any_grant_o  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/imem_fetch_arbiter.sv
// Shares one IMEM read port among the SIMD cores; grant is combinational, data returns IMEM_LATENCY+1 cycles later.
// No grant while imem_ready is low; in-flight tags keep advancing regardless.
module imem_fetch_arbiter
  import gpu_pkg::*;
#(
  parameter int IMEM_LATENCY = 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_SIMD_CORES-1:0]        fetch_req,
  input  logic [NUM_SIMD_CORES-1:0][31:0]  fetch_pc,
  input  logic [NUM_SIMD_CORES-1:0]        flush,
  output logic [NUM_SIMD_CORES-1:0]        fetch_gnt,
  output logic [NUM_SIMD_CORES-1:0]        instr_valid,
  output logic [31:0]                      instr_out,
  output logic                             imem_req,
  output logic [31:0]                      imem_addr,
  input  logic                             imem_ready,
  input  logic [31:0]                      instruction_from_imem,
  output logic [NUM_SIMD_CORES-1:0]        misalign_err,
  output logic                             busy
);

  logic [LOG2_SIMD_CORES-1:0] rr_ptr_q, rr_ptr_d;
  logic [NUM_SIMD_CORES-1:0]  inflight_q, inflight_d;
  logic [NUM_SIMD_CORES-1:0]  instr_valid_q, instr_valid_d;
  logic [31:0]                instr_out_q, instr_out_d;
  logic [NUM_SIMD_CORES-1:0]  misalign_q, misalign_d;
  fetch_tag_t                 tag_q [IMEM_LATENCY];
  fetch_tag_t                 tag_d [IMEM_LATENCY];

  logic [NUM_SIMD_CORES-1:0]  eligible;
  logic [NUM_SIMD_CORES-1:0]  arb_grant;
  logic [LOG2_SIMD_CORES-1:0] arb_winner;
  logic                       arb_any;
  fetch_tag_t                 exit_tag;
  logic                       deliver;
  logic [NUM_SIMD_CORES-1:0]  deliver_vec;

  assign eligible = fetch_req & ~inflight_q & ~flush & {NUM_SIMD_CORES{imem_ready}};

  rr_arbiter #(
    .N (NUM_SIMD_CORES),
    .W (LOG2_SIMD_CORES)
  ) u_rr_arbiter (
    .eligible_i  (eligible),
    .rr_ptr_i    (rr_ptr_q),
    .grant_o     (arb_grant),
    .winner_o    (arb_winner),
    .any_grant_o (arb_any)
  );

  assign fetch_gnt = arb_grant;
  assign imem_req  = arb_any;
  assign imem_addr = arb_any ? {fetch_pc[arb_winner][31:2], 2'b00} : 32'h0;

  always_comb begin
    tag_d[0].valid   = arb_any;
    tag_d[0].core_id = arb_winner;
    // Flushed cores lose their tags as they shift, so stale data is never delivered.
    for (int s = 1; s < IMEM_LATENCY; s++) begin
      tag_d[s] = tag_q[s-1];
      if (flush[tag_q[s-1].core_id]) tag_d[s].valid = 1'b0;
    end

    exit_tag    = tag_q[IMEM_LATENCY-1];
    deliver     = exit_tag.valid && inflight_q[exit_tag.core_id] && !flush[exit_tag.core_id];
    deliver_vec = '0;
    deliver_vec[exit_tag.core_id] = deliver;

    instr_valid_d = deliver_vec;
    instr_out_d   = deliver ? instruction_from_imem : instr_out_q;
    inflight_d    = (inflight_q & ~flush & ~deliver_vec) | arb_grant;

    misalign_d = misalign_q;
    if (arb_any && (fetch_pc[arb_winner][1:0] != 2'b00)) misalign_d = misalign_q | arb_grant;

    rr_ptr_d = rr_ptr_q;
    if (arb_any) begin
      rr_ptr_d = (arb_winner == LOG2_SIMD_CORES'(NUM_SIMD_CORES - 1)) ? '0 : arb_winner + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr_q      <= '0;
      inflight_q    <= '0;
      instr_valid_q <= '0;
      instr_out_q   <= '0;
      misalign_q    <= '0;
      for (int s = 0; s < IMEM_LATENCY; s++) tag_q[s] <= '0;
    end else begin
      rr_ptr_q      <= rr_ptr_d;
      inflight_q    <= inflight_d;
      instr_valid_q <= instr_valid_d;
      instr_out_q   <= instr_out_d;
      misalign_q    <= misalign_d;
      for (int s = 0; s < IMEM_LATENCY; s++) tag_q[s] <= tag_d[s];
    end
  end

  assign instr_valid  = instr_valid_q;
  assign instr_out    = instr_out_q;
  assign misalign_err = misalign_q;
  assign busy         = |inflight_q;

endmodule

// File: tb/tb_imem_fetch_arbiter.sv
// Bench for imem_fetch_arbiter: latency-1 and latency-2 instances share stimulus; vector table, directed corners, random vs model.
module tb_imem_fetch_arbiter;

  logic             clk = 1'b0;
  logic             rst;
  logic [3:0]       fetch_req;
  logic [3:0][31:0] fetch_pc;
  logic [3:0]       flush;
  logic             imem_ready;
  logic [31:0]      instruction_from_imem;

  logic [3:0]  gnt_a, vld_a, mis_a, gnt_b, vld_b, mis_b;
  logic [31:0] out_a, addr_a, out_b, addr_b;
  logic        ireq_a, busy_a, ireq_b, busy_b;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  imem_fetch_arbiter #(.IMEM_LATENCY(1)) dut_a (
    .clk(clk), .rst(rst), .fetch_req(fetch_req), .fetch_pc(fetch_pc), .flush(flush),
    .fetch_gnt(gnt_a), .instr_valid(vld_a), .instr_out(out_a), .imem_req(ireq_a),
    .imem_addr(addr_a), .imem_ready(imem_ready), .instruction_from_imem(instruction_from_imem),
    .misalign_err(mis_a), .busy(busy_a)
  );

  imem_fetch_arbiter #(.IMEM_LATENCY(2)) dut_b (
    .clk(clk), .rst(rst), .fetch_req(fetch_req), .fetch_pc(fetch_pc), .flush(flush),
    .fetch_gnt(gnt_b), .instr_valid(vld_b), .instr_out(out_b), .imem_req(ireq_b),
    .imem_addr(addr_b), .imem_ready(imem_ready), .instruction_from_imem(instruction_from_imem),
    .misalign_err(mis_b), .busy(busy_b)
  );

  typedef struct {
    bit          rst_before;
    logic [3:0]  req;
    logic [3:0]  fl;
    logic        rdy;
    logic [31:0] data;
    logic [3:0]  gnt;
    logic        ireq;
    bit          chk_addr;
    logic [31:0] addr;
    logic [3:0]  vld;
    logic [31:0] out;
    logic        busy;
  } vec_t;

  vec_t tv[$];

  task automatic add(input bit rb, input logic [3:0] req, input logic [3:0] fl, input logic rdy,
                     input logic [31:0] data, input logic [3:0] gnt, input logic ireq,
                     input bit ca, input logic [31:0] addr, input logic [3:0] vld,
                     input logic [31:0] out, input logic busy);
    vec_t v;
    v.rst_before = rb; v.req = req; v.fl = fl; v.rdy = rdy; v.data = data;
    v.gnt = gnt; v.ireq = ireq; v.chk_addr = ca; v.addr = addr; v.vld = vld;
    v.out = out; v.busy = busy;
    tv.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // Called just after a rising edge; reset pulses and releases well before the next edge.
  task automatic do_reset();
    fetch_req = '0;
    flush     = '0;
    rst       = 1'b0;
    #2;
    rst       = 1'b1;
  endtask

  task automatic drive(input logic [3:0] req, input logic [3:0] fl, input logic rdy, input logic [31:0] data);
    fetch_req = req; flush = fl; imem_ready = rdy; instruction_from_imem = data;
    @(negedge clk);
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  // Reference model: per-core outstanding flag and the cycle its IMEM data is due.
  bit   [3:0]  m_inf [2];
  int          m_due [2][4];
  int          m_ptr [2];
  logic [3:0]  m_vld [2];
  logic [31:0] m_out [2];
  logic [3:0]  m_mis [2];
  int          cyc;

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      m_inf[m] = '0; m_ptr[m] = 0; m_vld[m] = '0; m_out[m] = '0; m_mis[m] = '0;
      for (int i = 0; i < 4; i++) m_due[m][i] = -1;
    end
    cyc = 0;
  endtask

  task automatic model_step(input int m, input int lat);
    logic [3:0]  elig, g, dv;
    logic [3:0]  a_gnt, a_vld, a_mis;
    logic [31:0] a_out, a_addr;
    logic        a_ireq, a_busy;
    bit          any;
    int          w;
    a_gnt  = (m == 0) ? gnt_a  : gnt_b;
    a_vld  = (m == 0) ? vld_a  : vld_b;
    a_mis  = (m == 0) ? mis_a  : mis_b;
    a_out  = (m == 0) ? out_a  : out_b;
    a_addr = (m == 0) ? addr_a : addr_b;
    a_ireq = (m == 0) ? ireq_a : ireq_b;
    a_busy = (m == 0) ? busy_a : busy_b;

    elig = fetch_req & ~m_inf[m] & ~flush;
    any  = 1'b0;
    w    = 0;
    if (imem_ready) begin
      for (int k = 0; k < 4; k++) begin
        int c;
        c = (m_ptr[m] + k) % 4;
        if (!any && elig[c]) begin any = 1'b1; w = c; end
      end
    end
    g = any ? 4'(1 << w) : 4'b0000;

    chk($sformatf("rnd%0d c%0d gnt", m, cyc), 32'(a_gnt), 32'(g));
    chk($sformatf("rnd%0d c%0d imem_req", m, cyc), 32'(a_ireq), 32'(any));
    if (any) chk($sformatf("rnd%0d c%0d addr", m, cyc), a_addr, {fetch_pc[w][31:2], 2'b00});
    chk($sformatf("rnd%0d c%0d vld", m, cyc), 32'(a_vld), 32'(m_vld[m]));
    chk($sformatf("rnd%0d c%0d out", m, cyc), a_out, m_out[m]);
    chk($sformatf("rnd%0d c%0d busy", m, cyc), 32'(a_busy), 32'(|m_inf[m]));
    chk($sformatf("rnd%0d c%0d mis", m, cyc), 32'(a_mis), 32'(m_mis[m]));

    dv = '0;
    for (int i = 0; i < 4; i++)
      if (m_inf[m][i] && m_due[m][i] == cyc && !flush[i]) dv[i] = 1'b1;
    m_vld[m] = dv;
    if (dv != 4'b0000) m_out[m] = instruction_from_imem;
    m_inf[m] = (m_inf[m] & ~flush & ~dv) | g;
    if (any) begin
      m_due[m][w] = cyc + lat;
      if (fetch_pc[w][1:0] != 2'b00) m_mis[m][w] = 1'b1;
      m_ptr[m] = (w + 1) % 4;
    end
  endtask

  initial begin
    rst = 1'b0; fetch_req = '0; flush = '0; imem_ready = 1'b0; instruction_from_imem = '0;
    fetch_pc[0] = 32'h100; fetch_pc[1] = 32'h200; fetch_pc[2] = 32'h40; fetch_pc[3] = 32'h300;

    // Single request (latency 1), then fairness, then backpressure.
    add(1, 4'b0000, 4'b0, 1, 32'h0,        4'b0000, 0, 1, 32'h0,   4'b0000, 32'h0,        0);
    add(0, 4'b0100, 4'b0, 1, 32'h0,        4'b0100, 1, 1, 32'h40,  4'b0000, 32'h0,        0);
    add(0, 4'b0000, 4'b0, 1, 32'hDEAD0001, 4'b0000, 0, 1, 32'h0,   4'b0000, 32'h0,        1);
    add(0, 4'b0000, 4'b0, 1, 32'h0,        4'b0000, 0, 1, 32'h0,   4'b0100, 32'hDEAD0001, 0);
    add(1, 4'b1111, 4'b0, 1, 32'hA0,       4'b0001, 1, 1, 32'h100, 4'b0000, 32'h0,        0);
    add(0, 4'b1111, 4'b0, 1, 32'hA1,       4'b0010, 1, 1, 32'h200, 4'b0000, 32'h0,        1);
    add(0, 4'b1111, 4'b0, 1, 32'hA2,       4'b0100, 1, 1, 32'h40,  4'b0001, 32'hA1,       1);
    add(0, 4'b1111, 4'b0, 1, 32'hA3,       4'b1000, 1, 1, 32'h300, 4'b0010, 32'hA2,       1);
    add(0, 4'b1111, 4'b0, 1, 32'hA4,       4'b0001, 1, 1, 32'h100, 4'b0100, 32'hA3,       1);
    add(0, 4'b1111, 4'b0, 1, 32'hA5,       4'b0010, 1, 1, 32'h200, 4'b1000, 32'hA4,       1);
    add(0, 4'b1111, 4'b0, 1, 32'hA6,       4'b0100, 1, 1, 32'h40,  4'b0001, 32'hA5,       1);
    add(1, 4'b1010, 4'b0, 0, 32'h0,        4'b0000, 0, 0, 32'h0,   4'b0000, 32'h0,        0);
    add(0, 4'b1010, 4'b0, 0, 32'h0,        4'b0000, 0, 0, 32'h0,   4'b0000, 32'h0,        0);
    add(0, 4'b1010, 4'b0, 0, 32'h0,        4'b0000, 0, 0, 32'h0,   4'b0000, 32'h0,        0);
    add(0, 4'b1010, 4'b0, 1, 32'h0,        4'b0010, 1, 1, 32'h200, 4'b0000, 32'h0,        0);
    add(0, 4'b1000, 4'b0, 1, 32'hB4,       4'b1000, 1, 1, 32'h300, 4'b0000, 32'h0,        1);
    add(0, 4'b0000, 4'b0, 1, 32'hB5,       4'b0000, 0, 1, 32'h0,   4'b0010, 32'hB4,       1);
    add(0, 4'b0000, 4'b0, 1, 32'h0,        4'b0000, 0, 1, 32'h0,   4'b1000, 32'hB5,       0);

    adv();
    rst = 1'b1;
    foreach (tv[r]) begin
      if (tv[r].rst_before) do_reset();
      drive(tv[r].req, tv[r].fl, tv[r].rdy, tv[r].data);
      chk($sformatf("row%0d gnt", r), 32'(gnt_a), 32'(tv[r].gnt));
      chk($sformatf("row%0d imem_req", r), 32'(ireq_a), 32'(tv[r].ireq));
      if (tv[r].chk_addr) chk($sformatf("row%0d addr", r), addr_a, tv[r].addr);
      chk($sformatf("row%0d vld", r), 32'(vld_a), 32'(tv[r].vld));
      chk($sformatf("row%0d out", r), out_a, tv[r].out);
      chk($sformatf("row%0d busy", r), 32'(busy_a), 32'(tv[r].busy));
      adv();
    end

    // Misaligned PC, then asynchronous reset while that fetch is in flight.
    fetch_pc[1] = 32'h43;
    drive(4'b0010, 4'b0, 1, 32'h0);
    chk("mis gnt", 32'(gnt_a), 32'h2);
    chk("mis addr", addr_a, 32'h40);
    chk("mis err before", 32'(mis_a), 32'h0);
    adv();
    drive(4'b0000, 4'b0, 1, 32'hC1);
    chk("mis err", 32'(mis_a), 32'h2);
    chk("mis busy", 32'(busy_a), 32'h1);
    #1 rst = 1'b0;
    #1;
    chk("arst mis", 32'(mis_a), 32'h0);
    chk("arst busy", 32'(busy_a), 32'h0);
    chk("arst out", out_a, 32'h0);
    chk("arst vld", 32'(vld_a), 32'h0);
    chk("arst imem_req", 32'(ireq_a), 32'h0);
    adv();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(4'b0000, 4'b0, 1, 32'hBAD00000 + 32'(i));
      chk($sformatf("post-rst%0d vld", i), 32'(vld_a), 32'h0);
      chk($sformatf("post-rst%0d out", i), out_a, 32'h0);
      adv();
    end

    // Flush one cycle after grant on the latency-2 instance.
    fetch_pc[0] = 32'h100;
    do_reset();
    drive(4'b0001, 4'b0000, 1, 32'h0);
    chk("fl gnt", 32'(gnt_b), 32'h1);
    adv();
    drive(4'b0000, 4'b0001, 1, 32'h0);
    chk("fl busy during", 32'(busy_b), 32'h1);
    adv();
    drive(4'b0001, 4'b0000, 1, 32'h0);
    chk("fl busy after", 32'(busy_b), 32'h0);
    chk("fl regrant", 32'(gnt_b), 32'h1);
    chk("fl vld c2", 32'(vld_b), 32'h0);
    adv();
    drive(4'b0000, 4'b0000, 1, 32'h11);
    chk("fl vld c3", 32'(vld_b), 32'h0);
    adv();
    drive(4'b0000, 4'b0000, 1, 32'hF00D);
    chk("fl vld c4", 32'(vld_b), 32'h0);
    adv();
    drive(4'b0000, 4'b0000, 1, 32'h0);
    chk("fl vld c5", 32'(vld_b), 32'h1);
    chk("fl out c5", out_b, 32'hF00D);
    adv();

    // Random traffic on both instances against the model.
    do_reset();
    model_reset();
    for (int n = 0; n < 400; n++) begin
      logic [31:0] r;
      for (int i = 0; i < 4; i++) begin
        r = $urandom;
        fetch_pc[i] = {r[31:2], ($urandom_range(0, 7) == 0) ? 2'b01 : 2'b00};
      end
      r = $urandom;
      fetch_req  = r[3:0];
      flush      = ($urandom_range(0, 5) == 0) ? r[7:4] : 4'b0000;
      imem_ready = ($urandom_range(0, 3) != 0);
      instruction_from_imem = $urandom;
      @(negedge clk);
      model_step(0, 1);
      model_step(1, 2);
      cyc++;
      adv();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/imem_fetch_arbiter.md
# imem_fetch_arbiter

Shares the single instruction memory port among all SIMD cores. Each core presents a fetch PC. The block round-robin arbitrates among those requests, issues one word address per cycle to the IMEM, and tracks each in-flight fetch with a tag pipeline. It then returns the fetched instruction to the requesting core as a one-hot valid pulse. It sits between the simd_core array (downstream of each core's PC output) and the external IMEM that drives `instruction_from_imem`.

## Interface
- `NUM_SIMD_CORES`, 4: number of requesting cores, 2..8.
- `LOG2_SIMD_CORES`, 2: core-id width, equal to clog2(NUM_SIMD_CORES).
- `IMEM_LATENCY`, 1: IMEM read latency in cycles, 1..4.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous assert, active-low.
- `fetch_req`  in  [NUM_SIMD_CORES]  per-core request. The core holds it until granted.
- `fetch_pc`  in  32 x NUM_SIMD_CORES  per-core byte PC. Held stable with `fetch_req`.
- `flush`  in  [NUM_SIMD_CORES]  per-core kill for in-flight fetches (kernel end or branch).
- `fetch_gnt`  out  [NUM_SIMD_CORES]  one-hot, combinational, one-cycle request accept.
- `instr_valid`  out  [NUM_SIMD_CORES]  one-hot, registered, one-cycle instruction delivery.
- `instr_out`  out  32  registered instruction, shared by all cores. Qualified by `instr_valid`.
- `imem_req`  out  1  combinational IMEM read strobe.
- `imem_addr`  out  32  combinational IMEM byte address; bits [1:0] are always 0.
- `imem_ready`  in  1  IMEM can accept a read this cycle.
- `instruction_from_imem`  in  32  IMEM read data.
- `misalign_err`  out  [NUM_SIMD_CORES]  sticky flag; set when a core is granted with `fetch_pc[1:0]` != 0.
- `busy`  out  1  high when any fetch is in flight.

## Operation
- A core is eligible when all of these hold: `fetch_req[i]`, `!inflight[i]`, `!flush[i]`.
- At most one outstanding fetch is allowed per core.
- Grant happens when `imem_ready` is high and at least one core is eligible:
  - The winner is the first eligible core at or after `rr_ptr`, searching upward with wrap.
  - The block asserts `fetch_gnt[w]` and `imem_req`, and drives `imem_addr = {fetch_pc[w][31:2],2'b00}`.
- On a grant edge, `rr_ptr` updates to (w+1) mod NUM_SIMD_CORES. With no grant, `rr_ptr` holds.
- A grant sets `inflight[w]`.
- A grant pushes the tag {valid=1, core_id=w} into an IMEM_LATENCY-deep shift register. With no grant, the pushed tag has valid=0.
- When a tag exits the shift register with valid=1 and `inflight[id]` still set:
  - `instruction_from_imem` is registered into `instr_out`.
  - `instr_valid[id]` pulses for one cycle.
  - `inflight[id]` clears.
- `flush[i]` clears `inflight[i]` and invalidates every tag for core i in the shift register on that edge. The matching IMEM response is silently dropped.
- `busy` = OR of `inflight`.
- When `imem_ready` is low, there are no grants, `imem_req` is 0, and in-flight tags keep advancing.
- `misalign_err[i]` is cleared only by reset.

## Timing
- Request sampled and granted in cycle T → IMEM samples the address at the end of T → `instruction_from_imem` is valid in cycle T+IMEM_LATENCY → `instr_valid`/`instr_out` are asserted in cycle T+IMEM_LATENCY+1.
- Back-to-back grants go to different cores every cycle, giving one fetch per cycle of throughput.
- The earliest a core can be re-granted is the cycle of its own `instr_valid` pulse, because `inflight` is already clear then.
- Flush in the same cycle as that core's response: the response is dropped and `instr_valid` stays 0.
- Flush in the same cycle as that core's request: no grant.
- Reset (`rst` low, any cycle) asynchronously clears `rr_ptr`=0, all tags, `inflight`, `instr_valid`, `instr_out`=0, `misalign_err`, `busy`=0.
- After reset, the combinational outputs depend only on inputs and state: `fetch_gnt`=0, `imem_req`=0, `imem_addr`=0 when no core is eligible.
- IMEM data returning after a reset mid-operation is ignored because no valid tag exists.

## Structure
- Shared package `gpu_pkg` carries `NUM_SIMD_CORES`, `LOG2_SIMD_CORES`, and `fetch_tag_t` (struct: valid, core_id[LOG2_SIMD_CORES-1:0]).
- Sub-module `rr_arbiter`: parameterized round-robin pick.
  - Inputs: eligible vector and `rr_ptr`.
  - Outputs: one-hot grant, winner index, any_grant.
  - Purely combinational.
- Tag pipeline, `inflight`, and the output registers live in the top of this block.

## Test plan
- Single request: core 2 requests PC 0x40, with `imem_ready`=1 and IMEM_LATENCY=1.
  - Required: `fetch_gnt`=0100 in T, `imem_addr`=0x40, `instr_valid[2]` in T+2 with `instr_out` = the data driven in T+1.
- Fairness: all four cores request continuously from `rr_ptr`=0.
  - Required: grants go 0,1,2,3,0,... one per cycle; no core is granted twice within 4 grants.
- Backpressure: `imem_ready`=0 for 3 cycles while cores 1 and 3 request.
  - Required: no `fetch_gnt`, no `imem_req`; after `imem_ready` rises, core 1 is granted, then core 3.
- Flush in flight: core 0 is granted, then `flush[0]` is asserted at T+1 with IMEM_LATENCY=2.
  - Required: no `instr_valid[0]`; `busy` falls after the flush edge; core 0 is re-grantable the next cycle.
- Misalignment and reset: core 1 requests PC 0x43.
  - Required: `imem_addr`=0x40 and `misalign_err[1]`=1.
  - Drop `rst` mid-flight: all outputs clear asynchronously, and no `instr_valid` appears afterward.
